cnn_hls_mac_pipe: RTL and testbench

Pipelined, parametrised signed multiply-accumulate unit for CNN dot products. It is the next generation of the fixed-width single-cycle signed multipliers in the `cnn_hls` datapath. It accepts operand pairs under a valid/ready handshake, accumulates them over a vector delimited by `in_first`/`in_last`, then emits one shifted, rounded and saturated result per vector. It sits between the line-buffer operand fetch and the activation stage.

---
 rtl/cnn_hls_pkg.sv | 30 +++
 rtl/cnn_hls_mac_fmt.sv | 25 ++
 rtl/cnn_hls_mac_pipe.sv | 133 +++++++++++++
 tb/tb_cnn_hls_mac_pipe.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/cnn_hls_pkg.sv
// Shared definitions for the cnn_hls MAC datapath: legal pipeline depth and
// the round/shift/saturate helpers used when formatting an accumulator.
package cnn_hls_pkg;

  localparam int NUM_STAGE_MIN = 1;
  localparam int NUM_STAGE_MAX = 4;

  // Formatting runs on a wide signed value so the rounding add cannot overflow.
  localparam int FMT_W = 64;
  typedef logic signed [FMT_W-1:0] fmt_t;

  function automatic fmt_t round_shift(input fmt_t v, input int shift, input bit rnd);
    fmt_t r;
    r = v;
    if (rnd && shift > 0) r = r + (fmt_t'(1) <<< (shift - 1));
    return r >>> shift;
  endfunction

  function automatic fmt_t fit_width(input fmt_t v, input int w, input bit sat);
    fmt_t hi;
    fmt_t lo;
    hi = (fmt_t'(1) <<< (w - 1)) - fmt_t'(1);
    lo = -(fmt_t'(1) <<< (w - 1));
    if (!sat) return (v <<< (FMT_W - w)) >>> (FMT_W - w);
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

endpackage

// File: rtl/cnn_hls_mac_fmt.sv
// Combinational output formatter: optional round, arithmetic shift, then
// saturate or truncate to the result width; flags any value change.
module cnn_hls_mac_fmt
  import cnn_hls_pkg::*;
#(
  parameter int ACC_WIDTH  = 32,
  parameter int dout_WIDTH = 13,
  parameter int FRAC_SHIFT = 0,
  parameter int ROUND_EN   = 0,
  parameter int SAT_EN     = 1
) (
  input  logic [ACC_WIDTH-1:0]  acc,
  output logic [dout_WIDTH-1:0] dout,
  output logic                  ovf
);

  fmt_t shifted;
  fmt_t fitted;

  assign shifted = round_shift(FMT_W'($signed(acc)), FRAC_SHIFT, ROUND_EN != 0);
  assign fitted  = fit_width(shifted, dout_WIDTH, SAT_EN != 0);
  assign dout    = fitted[dout_WIDTH-1:0];
  assign ovf     = fitted != shifted;

endmodule

// File: rtl/cnn_hls_mac_pipe.sv
// Pipelined signed MAC: product pipeline, vector accumulator and a single
// entry formatted output register, all frozen by ce or output backpressure.
module cnn_hls_mac_pipe
  import cnn_hls_pkg::*;
#(
  parameter int din0_WIDTH = 13,
  parameter int din1_WIDTH = 13,
  parameter int ACC_WIDTH  = 32,
  parameter int dout_WIDTH = 13,
  parameter int NUM_STAGE  = 2,
  parameter int FRAC_SHIFT = 0,
  parameter int ROUND_EN   = 0,
  parameter int SAT_EN     = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  ce,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [din0_WIDTH-1:0] din0,
  input  logic [din1_WIDTH-1:0] din1,
  input  logic                  in_first,
  input  logic                  in_last,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [dout_WIDTH-1:0] dout,
  output logic                  out_ovf
);

  localparam int PROD_W = din0_WIDTH + din1_WIDTH;

  if (NUM_STAGE < NUM_STAGE_MIN || NUM_STAGE > NUM_STAGE_MAX) begin : g_bad_stage
    $error("cnn_hls_mac_pipe: NUM_STAGE out of range");
  end
  if (ACC_WIDTH < PROD_W || ACC_WIDTH > FMT_W - 2) begin : g_bad_acc
    $error("cnn_hls_mac_pipe: ACC_WIDTH out of range");
  end

  logic stall;
  logic adv;
  logic accept;
  logic signed [PROD_W-1:0] prod;

  logic [NUM_STAGE:1] vld_pipe;
  logic [NUM_STAGE:1] first_pipe;
  logic [NUM_STAGE:1] last_pipe;
  logic [NUM_STAGE:1][PROD_W-1:0] prod_pipe;

  logic signed [PROD_W-1:0]    prod_tail;
  logic signed [ACC_WIDTH-1:0] acc_q;
  logic signed [ACC_WIDTH-1:0] acc_base;
  logic signed [ACC_WIDTH-1:0] acc_sum;
  logic                        acc_done;

  logic [dout_WIDTH-1:0] fmt_dout;
  logic                  fmt_ovf;

  assign stall    = out_valid & ~out_ready;
  assign adv      = ce & ~stall;
  assign in_ready = adv & ~reset;
  assign accept   = in_valid & in_ready;
  assign prod     = PROD_W'($signed(din0)) * PROD_W'($signed(din1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld_pipe   <= '0;
      first_pipe <= '0;
      last_pipe  <= '0;
      prod_pipe  <= '0;
    end else if (adv) begin
      vld_pipe[1]   <= accept;
      first_pipe[1] <= in_first;
      last_pipe[1]  <= in_last;
      prod_pipe[1]  <= prod;
      for (int s = 2; s <= NUM_STAGE; s++) begin
        vld_pipe[s]   <= vld_pipe[s-1];
        first_pipe[s] <= first_pipe[s-1];
        last_pipe[s]  <= last_pipe[s-1];
        prod_pipe[s]  <= prod_pipe[s-1];
      end
    end
  end

  // acc_done marks a finished vector waiting to be formatted; the next
  // product must then start from zero even without in_first.
  assign prod_tail = prod_pipe[NUM_STAGE];
  assign acc_base  = (first_pipe[NUM_STAGE] | acc_done) ? '0 : acc_q;
  assign acc_sum   = acc_base + ACC_WIDTH'(prod_tail);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc_q    <= '0;
      acc_done <= 1'b0;
    end else if (adv) begin
      if (vld_pipe[NUM_STAGE]) begin
        acc_q    <= acc_sum;
        acc_done <= last_pipe[NUM_STAGE];
      end else if (acc_done) begin
        acc_q    <= '0;
        acc_done <= 1'b0;
      end
    end
  end

  cnn_hls_mac_fmt #(
    .ACC_WIDTH (ACC_WIDTH),
    .dout_WIDTH(dout_WIDTH),
    .FRAC_SHIFT(FRAC_SHIFT),
    .ROUND_EN  (ROUND_EN),
    .SAT_EN    (SAT_EN)
  ) u_fmt (
    .acc (acc_q),
    .dout(fmt_dout),
    .ovf (fmt_ovf)
  );

  // adv with out_valid set implies out_ready, so the held result is taken
  // and a new one can load in the same cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid <= 1'b0;
      dout      <= '0;
      out_ovf   <= 1'b0;
    end else if (adv) begin
      out_valid <= acc_done;
      if (acc_done) begin
        dout    <= fmt_dout;
        out_ovf <= fmt_ovf;
      end
    end
  end

endmodule

// File: tb/tb_cnn_hls_mac_pipe.sv
// Scoreboard bench: four formatting configurations share one stimulus stream;
// a monitor checks every delivered result against a plain-arithmetic model.
module tb_cnn_hls_mac_pipe;

  logic clk = 1'b0;
  logic reset, ce, in_valid, in_first, in_last, out_ready;
  logic [12:0] din0, din1;
  logic [3:0] rdy, ov, ovf;
  logic [3:0][12:0] dout;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc = 0;
  longint sb[$];
  longint sum = 0;
  longint last_d[4];
  bit     last_o[4];
  bit     rand_bp = 1'b0;

  // instance 0: defaults, 1: truncate, 2: shift 4 + round, 3: shift 4 no round
  int cfg_sh[4]  = '{0, 0, 4, 4};
  bit cfg_rnd[4] = '{0, 0, 1, 0};
  bit cfg_sat[4] = '{1, 0, 1, 1};

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  cnn_hls_mac_pipe u_def (.clk(clk), .reset(reset), .ce(ce), .in_valid(in_valid), .in_ready(rdy[0]),
    .din0(din0), .din1(din1), .in_first(in_first), .in_last(in_last), .out_valid(ov[0]),
    .out_ready(out_ready), .dout(dout[0]), .out_ovf(ovf[0]));
  cnn_hls_mac_pipe #(.SAT_EN(0)) u_wrap (.clk(clk), .reset(reset), .ce(ce), .in_valid(in_valid),
    .in_ready(rdy[1]), .din0(din0), .din1(din1), .in_first(in_first), .in_last(in_last),
    .out_valid(ov[1]), .out_ready(out_ready), .dout(dout[1]), .out_ovf(ovf[1]));
  cnn_hls_mac_pipe #(.FRAC_SHIFT(4), .ROUND_EN(1)) u_rnd (.clk(clk), .reset(reset), .ce(ce),
    .in_valid(in_valid), .in_ready(rdy[2]), .din0(din0), .din1(din1), .in_first(in_first),
    .in_last(in_last), .out_valid(ov[2]), .out_ready(out_ready), .dout(dout[2]), .out_ovf(ovf[2]));
  cnn_hls_mac_pipe #(.FRAC_SHIFT(4)) u_trn (.clk(clk), .reset(reset), .ce(ce), .in_valid(in_valid),
    .in_ready(rdy[3]), .din0(din0), .din1(din1), .in_first(in_first), .in_last(in_last),
    .out_valid(ov[3]), .out_ready(out_ready), .dout(dout[3]), .out_ovf(ovf[3]));

  task automatic check(input string name, input longint act, input longint exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic longint wrap32(input longint v);
    longint m, r;
    m = 64'sh1_0000_0000;
    r = ((v % m) + m) % m;
    if (r >= m / 2) r = r - m;
    return r;
  endfunction

  function automatic void fmt_model(input longint acc, input int i, output longint d, output bit o);
    longint p, q;
    p = longint'(1) << cfg_sh[i];
    q = acc;
    if (cfg_rnd[i] && cfg_sh[i] > 0) q = q + p / 2;
    q = (q >= 0) ? q / p : -((-q + p - 1) / p);
    if (cfg_sat[i]) d = (q > 4095) ? 4095 : (q < -4096) ? -4096 : q;
    else begin
      d = ((q % 8192) + 8192) % 8192;
      if (d >= 4096) d = d - 8192;
    end
    o = (d != q);
  endfunction

  // Monitor: a handshake happens at the next rising edge when this holds.
  always @(negedge clk) begin
    longint acc, d;
    bit o;
    if (!reset && ce && out_ready && ov[0]) begin
      if (sb.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_output: got dout %0d, expected no result", $signed(dout[0]));
      end else begin
        acc = sb.pop_front();
        for (int i = 0; i < 4; i++) begin
          fmt_model(acc, i, d, o);
          check($sformatf("dout_cfg%0d acc=%0d", i, acc), longint'($signed(dout[i])), d);
          check($sformatf("ovf_cfg%0d acc=%0d", i, acc), longint'(ovf[i]), longint'(o));
          check($sformatf("valid_cfg%0d", i), longint'(ov[i]), 1);
          last_d[i] = longint'($signed(dout[i]));
          last_o[i] = ovf[i];
        end
      end
    end
  end

  initial forever begin
    @(posedge clk);
    #1;
    if (rand_bp) out_ready = ($urandom_range(0, 3) != 0);
  end

  task automatic send(input int a, input int b, input bit f, input bit l);
    int k;
    din0 = 13'(a);
    din1 = 13'(b);
    in_first = f;
    in_last = l;
    in_valid = 1'b1;
    k = 0;
    @(negedge clk);
    while (!rdy[0] && k < 200) begin
      @(negedge clk);
      k++;
    end
    if (k >= 200) begin
      n_tests++;
      n_fail++;
      $display("FAIL send_timeout: in_ready low for %0d cycles, expected accept", k);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    sum = wrap32((f ? 64'sd0 : sum) + longint'(a) * longint'(b));
    if (l) begin
      sb.push_back(sum);
      sum = 0;
    end
  endtask

  task automatic bubble();
    in_valid = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int k;
    k = 0;
    while (sb.size() != 0 && k < 500) begin
      @(posedge clk);
      k++;
    end
    if (sb.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL drain_timeout: %0d results pending, expected 0", sb.size());
      sb.delete();
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic lat_check(input int a, input int b, input int gap, input int exp_lat, input string name);
    int t0;
    send(a, b, 1'b1, 1'b1);
    t0 = cyc;
    if (gap > 0) begin
      ce = 1'b0;
      @(negedge clk);
      check("in_ready_ce_low", longint'(rdy[0]), 0);
      repeat (gap) @(posedge clk);
      #1;
      ce = 1'b1;
    end
    for (int k = 0; k < 40 && !ov[0]; k++) @(negedge clk);
    check(name, cyc - t0, exp_lat);
    drain();
  endtask

  initial begin
    reset = 1'b1; ce = 1'b1; in_valid = 1'b0; in_first = 1'b0; in_last = 1'b0;
    out_ready = 1'b1; din0 = '0; din1 = '0;
    #12;
    check("reset_in_ready", longint'(rdy[0]), 0);
    check("reset_out_valid", longint'(ov[0]), 0);
    check("reset_dout", longint'(dout[0]), 0);
    check("reset_ovf", longint'(ovf[0]), 0);
    @(posedge clk); #1; reset = 1'b0;
    @(posedge clk); #1;

    lat_check(-5, 7, 0, 3, "latency_single");
    check("single_dout", last_d[0], -35);
    check("single_ovf", longint'(last_o[0]), 0);

    send(100, 20, 1, 0); send(-30, 40, 0, 0); bubble(); send(7, -8, 0, 0); send(1, 1, 0, 1);
    drain();
    check("vector_dout", last_d[0], 745);

    send(64, 64, 1, 1); drain();
    check("sat_dout", last_d[0], 4095);
    check("sat_ovf", longint'(last_o[0]), 1);
    check("wrap_dout", last_d[1], -4096);
    check("wrap_ovf", longint'(last_o[1]), 1);

    send(25, 3, 1, 1); drain();
    check("round_pos", last_d[2], 5);
    check("noround_pos", last_d[3], 4);
    send(-25, 3, 1, 1); drain();
    check("round_neg", last_d[2], -5);

    // backpressure: hold the first result for 5 cycles while a vector streams
    fork
      begin
        send(3, 4, 1, 0); send(5, 6, 0, 0); send(-7, 8, 0, 1);
        send(9, 9, 1, 0); send(-2, 11, 0, 0); send(4, 4, 0, 0); send(1, -1, 0, 0); send(6, 6, 0, 1);
      end
      begin
        for (int k = 0; k < 40 && !ov[0]; k++) begin @(posedge clk); #1; end
        out_ready = 1'b0;
        @(negedge clk);
        check("stall_in_ready", longint'(rdy[0]), 0);
        repeat (5) @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    drain();

    lat_check(12, -3, 4, 7, "latency_ce_gap");
    check("ce_gap_dout", last_d[0], -36);

    // reset mid-vector discards the partial sum
    send(9, 9, 1, 0); send(4, 4, 0, 0);
    #3 reset = 1'b1;
    sum = 0;
    #1 check("reset_mid_valid", longint'(ov[0]), 0);
    @(posedge clk); #3 reset = 1'b0;
    @(posedge clk); #1;
    send(2, 3, 1, 1); drain();
    check("post_reset_dout", last_d[0], 6);

    // reset with a result pending
    out_ready = 1'b0;
    send(10, 10, 1, 1);
    for (int k = 0; k < 40 && !ov[0]; k++) @(negedge clk);
    check("pending_valid", longint'(ov[0]), 1);
    #2 reset = 1'b1;
    #1;
    check("pending_reset_valid", longint'(ov[0]), 0);
    check("pending_reset_dout", longint'(dout[0]), 0);
    sb.delete();
    @(posedge clk); #3 reset = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;

    rand_bp = 1'b1;
    for (int v = 0; v < 40; v++) begin
      int len;
      len = $urandom_range(1, 6);
      for (int p = 0; p < len; p++) begin
        send(int'($urandom_range(0, 8191)) - 4096, int'($urandom_range(0, 8191)) - 4096,
             p == 0, p == len - 1);
        if ($urandom_range(0, 3) == 0) bubble();
      end
    end
    rand_bp = 1'b0;
    @(posedge clk); #2 out_ready = 1'b1;
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
